// File: rtl/irq_pending_latch.sv
// Edge-capturing IRQ front end: pend after edge k (k+2 with IRQ_SYNC_EN), irq after next edge;
// irq holds until ack (or ACK_TIMEOUT cycles), then one GAP cycle. IRQ_SYNC_EN adds a 2-flop input synchronizer.
`timescale 1ns/1ps
module irq_pending_latch #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq_in,
  input  logic [3:0] mask,
  output logic [3:0] pend,
  output logic [3:0] pend_vec,
  input  logic [1:0] enc_id,
  input  logic       enc_valid,
  output logic       irq,
  output logic [1:0] irq_id,
  input  logic       ack,
  output logic       timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_e;

  localparam bit         TO_EN    = (ACK_TIMEOUT != 0);
  localparam logic [7:0] CNT_LAST = TO_EN ? 8'(ACK_TIMEOUT - 1) : 8'd0;

  state_e     state_q, state_d;
  logic [3:0] in_s;
  logic [3:0] prev_q;
  logic [3:0] pend_q, pend_d;
  logic [3:0] rise;
  logic [3:0] clr;
  logic       irq_q, irq_d;
  logic [1:0] irq_id_q, irq_id_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

`ifdef IRQ_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = irq_in;
`endif

  assign rise = in_s & ~prev_q;
  // A new edge outranks a same-cycle acknowledge clear.
  assign pend_d = (pend_q & ~clr) | rise;

  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    irq_id_d  = irq_id_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    clr       = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (enc_valid) begin
          irq_id_d = enc_id;
          irq_d    = 1'b1;
          cnt_d    = 8'd0;
          state_d  = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (ack) begin
          clr     = 4'b0001 << irq_id_q;
          irq_d   = 1'b0;
          state_d = S_GAP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          irq_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_GAP;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      prev_q    <= 4'd0;
      pend_q    <= 4'd0;
      irq_q     <= 1'b0;
      irq_id_q  <= 2'd0;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= in_s;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign pend     = pend_q;
  assign pend_vec = pend_q & mask;
  assign irq      = irq_q;
  assign irq_id   = irq_id_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed stimulus queues expected irq rise/fall/timeout
// events; a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_irq_pending_latch;

`ifdef IRQ_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  localparam int TO      = 4;
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_TO   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] irq_in = 4'd0;
  logic [3:0] mask = 4'd0;
  logic       ack = 1'b0;
  logic [3:0] pend, pend_vec;
  logic [1:0] enc_id;
  logic       enc_valid;
  logic       irq;
  logic [1:0] irq_id;
  logic       timeout;

  always #5 clk = ~clk;

  // Reference 4-to-2 priority encoder: highest set index wins.
  always_comb begin
    enc_valid = |pend_vec;
    enc_id    = 2'd0;
    for (int i = 0; i < 4; i++)
      if (pend_vec[i]) enc_id = 2'(i);
  end

  irq_pending_latch #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask),
    .pend(pend), .pend_vec(pend_vec), .enc_id(enc_id), .enc_valid(enc_valid),
    .irq(irq), .irq_id(irq_id), .ack(ack), .timeout(timeout)
  );

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {
    int kind;
    int id;
    int at;
  } ev_t;
  ev_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int id, input int at);
    ev_t e;
    e.kind = kind;
    e.id   = id;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: got kind %0d id %0d at cycle %0d, need nothing", kind, irq_id, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.id != int'(irq_id) || e.at != cyc) begin
        n_err++;
        $display("FAIL event: got kind %0d id %0d at cycle %0d, need kind %0d id %0d at cycle %0d",
                 kind, irq_id, cyc, e.kind, e.id, e.at);
      end
    end
  endtask

  logic irq_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      irq_prev = 1'b0;
    end else begin
      if (irq && !irq_prev) got_ev(EV_RISE);
      if (!irq && irq_prev) got_ev(EV_FALL);
      if (timeout)          got_ev(EV_TO);
      irq_prev = irq;
    end
  end

  // Advance to just after rising edge n (counted from reset release).
  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c, e;
    repeat (2) @(posedge clk);
    #1;
    check("reset pend", pend, 0);
    check("reset pend_vec", pend_vec, 0);
    check("reset irq", irq, 0);
    check("reset irq_id", irq_id, 0);
    check("reset timeout", timeout, 0);

    // Single pulse on line 2, immediate ack.
    mask = 4'hF; irq_in = 4'b0100; rst_n = 1'b1;
    expect_ev(EV_RISE, 2, 2 + S);
    at(1); irq_in = 4'b0000;
    at(1 + S);
    check("t1 pend", pend, 4'b0100);
    check("t1 pend_vec", pend_vec, 4'b0100);
    at(2 + S); ack = 1'b1;
    expect_ev(EV_FALL, 2, 3 + S);
    at(3 + S); ack = 1'b0;
    check("t1 pend cleared", pend, 0);
    check("t1 irq low", irq, 0);

    // Two lines at once: 3 first, then 1 after the gap.
    c = cyc + 2;
    at(c); irq_in = 4'b1010;
    expect_ev(EV_RISE, 3, c + 2 + S);
    at(c + 1); irq_in = 4'b0000;
    at(c + 1 + S);
    check("t2 pend", pend, 4'b1010);
    at(c + 2 + S); ack = 1'b1;
    expect_ev(EV_FALL, 3, c + 3 + S);
    expect_ev(EV_RISE, 1, c + 5 + S);
    at(c + 3 + S); ack = 1'b0;
    check("t2 pend after ack", pend, 4'b0010);
    at(c + 4 + S);
    check("t2 irq in gap", irq, 0);
    at(c + 5 + S); ack = 1'b1;
    expect_ev(EV_FALL, 1, c + 6 + S);
    at(c + 6 + S); ack = 1'b0;
    check("t2 pend empty", pend, 0);

    // Masked line latches but is not offered until unmasked.
    c = cyc + 2;
    at(c); mask = 4'b0111; irq_in = 4'b1000;
    at(c + 1 + S);
    check("t3 pend", pend, 4'b1000);
    check("t3 pend_vec", pend_vec, 0);
    at(c + 4 + S);
    check("t3 irq masked", irq, 0);
    mask = 4'hF;
    expect_ev(EV_RISE, 3, c + 5 + S);
    at(c + 5 + S); ack = 1'b1; irq_in = 4'b0000;
    expect_ev(EV_FALL, 3, c + 6 + S);
    at(c + 6 + S); ack = 1'b0;
    check("t3 pend cleared", pend, 0);

    // Timeout, ack ignored in GAP, re-offer, ack racing a new edge, reset mid-ACTIVE.
    c = cyc + 3;
    e = c + 2 + S;
    at(c); irq_in = 4'b0001;
    expect_ev(EV_RISE, 0, e);
    expect_ev(EV_FALL, 0, e + TO);
    expect_ev(EV_TO, 0, e + TO);
    at(c + 1); irq_in = 4'b0000;
    at(e + 4); ack = 1'b1;
    if (S != 0) irq_in = 4'b0001;
    expect_ev(EV_RISE, 0, e + 6);
    at(e + 5); ack = 1'b0;
    check("t4 pend kept after timeout", pend, 4'b0001);
    check("t4 timeout single pulse", timeout, 0);
    at(e + 6); ack = 1'b1; irq_in = 4'b0001;
    expect_ev(EV_FALL, 0, e + 7);
    expect_ev(EV_RISE, 0, e + 9);
    at(e + 7); ack = 1'b0;
    check("t5 set wins over clear", pend, 4'b0001);
    at(e + 9);
    @(negedge clk);
    #1;
    check("t5 irq before reset", irq, 1);
    rst_n = 1'b0;
    #1;
    check("t5 reset irq", irq, 0);
    check("t5 reset pend", pend, 0);
    check("t5 reset pend_vec", pend_vec, 0);

    // Line held high through reset release gives exactly one event.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_ev(EV_RISE, 0, 2 + S);
    at(2 + S); ack = 1'b1;
    expect_ev(EV_FALL, 0, 3 + S);
    at(3 + S); ack = 1'b0;
    check("t6 pend cleared", pend, 0);
    at(10 + S);
    check("t6 no second event pend", pend, 0);
    check("t6 no second event irq", irq, 0);

    check("events outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish, %0d vectors applied, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule
